bs_gclk_rate_ctrl: RTL and testbench
====================================

BS_GCLK_RATE_CTRL -- requirements
Module: bs_gclk_rate_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 8: number of gated clock channels (1..32).
REQ-002 SHALL have parameter HOLD, default 2: number of extra enabled cycles after a channel request drops (0..15).
REQ-003 SHALL have parameter CNT_W, default 17: width of the frame cycle counter.
REQ-004 SHALL have parameters CPF0/CPF1/CPF2/CPF3, defaults 100000/80000/60000/40000: cycles-per-frame budget per freq_sel code (each 2..2^CNT_W-1).
REQ-005 SHALL have parameter RATE_MASK, default NCH'b1: channels suppressed while waiting out the frame budget.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port freq_sel, input, 2: budget select (00→CPF0, 01→CPF1, 10→CPF2, 11→CPF3).
REQ-009 SHALL have port test_en, input, 1: forces every channel enable on.
REQ-010 SHALL have port ch_req, input, NCH: per-channel clock enable requests.
REQ-011 SHALL have port frame_start, input, 1: single-cycle pulse at the start-code boundary.
REQ-012 SHALL have port frame_done, input, 1: single-cycle pulse when the decoder finishes a frame.
REQ-013 SHALL have port overrun_clr, input, 1: clears the sticky overrun flag.
REQ-014 SHALL have port gclk, output, NCH: gated clocks.
REQ-015 SHALL have port ch_active, output, NCH: registered per-channel enable status.
REQ-016 SHALL have port end_of_one_frame, output, 1: single-cycle pulse.
REQ-017 SHALL have port frame_overrun, output, 1: sticky flag, frame exceeded its budget.
REQ-018 SHALL have port frame_cycles, output, CNT_W: cycles taken by the last completed frame.

Function
REQ-019 Per channel i, ena_i = test_en | (ch_req[i] | hold_cnt_i!=0) & !(RATE_MASK[i] & state==WAIT).
REQ-020 Each ena_i SHALL pass through a latch that is transparent while clk is low; gclk[i] = clk & latched ena_i, so no glitches and a one-half-cycle enable setup.
REQ-021 hold_cnt_i SHALL load HOLD when ch_req[i]=1, decrement when ch_req[i]=0 and the count is nonzero, and hold at 0 otherwise; HOLD=0 gives no extension.
REQ-022 ch_active[i] SHALL register ena_i on each posedge clk.
REQ-023 The FSM SHALL have states IDLE, COUNT, WAIT and OVER.
REQ-024 On frame_start in any state: counter←0, budget←CPF[freq_sel] (latched), state→COUNT; freq_sel changes mid-frame SHALL be ignored.
REQ-025 In COUNT, the counter SHALL increment once per cycle.
REQ-026 In COUNT, frame_done with counter<budget-1 SHALL set frame_cycles←counter+1 and state→WAIT.
REQ-027 In COUNT, when counter reaches budget-1 without frame_done: frame_overrun←1 and state→OVER.
REQ-028 In COUNT, frame_done in the same cycle as counter==budget-1 SHALL count as on-time: frame_cycles←budget, end_of_one_frame pulses, state→IDLE, no overrun.
REQ-029 In WAIT, the counter SHALL keep incrementing; at counter==budget-1: end_of_one_frame pulses for 1 cycle and state→IDLE.
REQ-030 In OVER, the counter SHALL saturate at 2^CNT_W-1; frame_done SHALL set frame_cycles←counter+1 (saturating), pulse end_of_one_frame, and set state→IDLE.
REQ-031 frame_start SHALL win over a simultaneous frame_done; the interrupted frame does not update frame_cycles.
REQ-032 frame_done in IDLE SHALL be ignored.
REQ-033 frame_overrun SHALL clear on overrun_clr only; a simultaneous set SHALL win.
REQ-034 All registered outputs SHALL change on posedge clk only.

Reset
REQ-035 Reset assertion SHALL immediately force: all latched enables 0 (gclk low), hold counters 0, ch_active 0, state IDLE, counter 0, budget CPF0, end_of_one_frame 0, frame_overrun 0, frame_cycles 0.
REQ-036 While reset is asserted, test_en SHALL NOT enable any clock.
REQ-037 Reset asserted mid-frame SHALL abandon the frame without producing an end_of_one_frame pulse.
REQ-038 Reset deassertion SHALL be usable asynchronously; the first state update occurs at the first posedge after release.

Verification
REQ-039 Scenario: NCH=8, HOLD=2, ch_req[3] high for 1 cycle → gclk[3] toggles for exactly 3 cycles, with no runt pulses; other channels stay low.
REQ-040 Scenario: CPF0=20, freq_sel=00, frame_start, frame_done after 8 cycles → frame_cycles=8; gclk[0] is suppressed until end_of_one_frame pulses 20 cycles after frame_start; frame_overrun stays 0.
REQ-041 Scenario: CPF1=10, freq_sel=01, no frame_done for 15 cycles → frame_overrun=1 at cycle 10; later frame_done → frame_cycles=16 and end_of_one_frame pulses; overrun_clr → frame_overrun=0.
REQ-042 Scenario: freq_sel changed from 00 to 11 mid-frame → the budget remains CPF0; the next frame_start uses CPF3.
REQ-043 Scenario: frame_start and frame_done in the same cycle during COUNT → counter restarts at 0, frame_cycles is unchanged, no end_of_one_frame pulse.
REQ-044 Scenario: reset pulsed while in WAIT with test_en=1 → all gclk are low during reset, state is IDLE afterwards, and no end_of_one_frame pulse is produced.

Source files
------------

// File: rtl/bs_gclk_rate_ctrl.sv
// Per-channel glitch-free clock gating with a frame-rate limiter: after an early
// frame_done, masked channels stay gated until the selected cycle budget expires.
module bs_gclk_rate_ctrl #(
  parameter int NCH = 8,
  parameter int HOLD = 2,
  parameter int CNT_W = 17,
  parameter int CPF0 = 100000,
  parameter int CPF1 = 80000,
  parameter int CPF2 = 60000,
  parameter int CPF3 = 40000,
  parameter logic [NCH-1:0] RATE_MASK = NCH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       freq_sel,
  input  logic             test_en,
  input  logic [NCH-1:0]   ch_req,
  input  logic             frame_start,
  input  logic             frame_done,
  input  logic             overrun_clr,
  output logic [NCH-1:0]   gclk,
  output logic [NCH-1:0]   ch_active,
  output logic             end_of_one_frame,
  output logic             frame_overrun,
  output logic [CNT_W-1:0] frame_cycles,
  output logic [1:0]       fsm_state
);

  // fsm_state is a debug view of the frame FSM: 0 IDLE, 1 COUNT, 2 WAIT, 3 OVER.
  typedef enum logic [1:0] {IDLE, COUNT, WAIT, OVER} state_t;

  localparam logic [3:0]       HOLD_V  = 4'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] budget;
  logic [3:0]       hold_cnt [NCH];
  logic [NCH-1:0]   ena;
  logic [NCH-1:0]   ena_lat;

  function automatic logic [CNT_W-1:0] cpf_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return CNT_W'(CPF0);
      2'd1:    return CNT_W'(CPF1);
      2'd2:    return CNT_W'(CPF2);
      default: return CNT_W'(CPF3);
    endcase
  endfunction

  always_comb begin
    ena = '0;
    for (int i = 0; i < NCH; i++) begin
      ena[i] = test_en | ((ch_req[i] | (hold_cnt[i] != 4'd0)) &
                          !(RATE_MASK[i] & (state == WAIT)));
    end
  end

  // Enable is captured while clk is low so gclk can only rise with clk.
  always_latch begin
    if (reset) begin
      ena_lat <= '0;
    end else if (!clk) begin
      ena_lat <= ena;
    end
  end

  assign gclk = {NCH{clk}} & ena_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) hold_cnt[i] <= 4'd0;
      ch_active <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_req[i]) begin
          hold_cnt[i] <= HOLD_V;
        end else if (hold_cnt[i] != 4'd0) begin
          hold_cnt[i] <= hold_cnt[i] - 4'd1;
        end
      end
      ch_active <= ena;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      counter          <= '0;
      budget           <= CNT_W'(CPF0);
      end_of_one_frame <= 1'b0;
      frame_overrun    <= 1'b0;
      frame_cycles     <= '0;
    end else begin
      end_of_one_frame <= 1'b0;
      // A set later in this block overrides the clear.
      if (overrun_clr) frame_overrun <= 1'b0;
      if (frame_start) begin
        counter <= '0;
        budget  <= cpf_of(freq_sel);
        state   <= COUNT;
      end else begin
        case (state)
          COUNT: begin
            counter <= counter + 1'b1;
            if (frame_done) begin
              frame_cycles <= counter + 1'b1;
              if (counter == budget - 1'b1) begin
                end_of_one_frame <= 1'b1;
                state            <= IDLE;
              end else begin
                state <= WAIT;
              end
            end else if (counter == budget - 1'b1) begin
              frame_overrun <= 1'b1;
              state         <= OVER;
            end
          end
          WAIT: begin
            counter <= counter + 1'b1;
            if (counter == budget - 1'b1) begin
              end_of_one_frame <= 1'b1;
              state            <= IDLE;
            end
          end
          OVER: begin
            if (counter != CNT_MAX) counter <= counter + 1'b1;
            if (frame_done) begin
              frame_cycles     <= (counter == CNT_MAX) ? CNT_MAX : counter + 1'b1;
              end_of_one_frame <= 1'b1;
              state            <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_bs_gclk_rate_ctrl.sv
// Bench for bs_gclk_rate_ctrl: directed frame scenarios checked against a
// frame-timeline model every cycle, plus hand-computed literal expectations.
module tb_bs_gclk_rate_ctrl;

  localparam int NCH = 8;
  localparam int HOLD = 2;
  localparam int CNT_W = 5;
  localparam int CPF0 = 20;
  localparam int CPF1 = 10;
  localparam int CPF2 = 15;
  localparam int CPF3 = 12;
  localparam int SAT = (1 << CNT_W) - 1;
  localparam logic [NCH-1:0] MASK = 8'h01;

  logic             clk;
  logic             reset;
  logic [1:0]       freq_sel;
  logic             test_en;
  logic [NCH-1:0]   ch_req;
  logic             frame_start;
  logic             frame_done;
  logic             overrun_clr;
  logic [NCH-1:0]   gclk;
  logic [NCH-1:0]   ch_active;
  logic             end_of_one_frame;
  logic             frame_overrun;
  logic [CNT_W-1:0] frame_cycles;
  logic [1:0]       fsm_state;

  bs_gclk_rate_ctrl #(
    .NCH(NCH), .HOLD(HOLD), .CNT_W(CNT_W),
    .CPF0(CPF0), .CPF1(CPF1), .CPF2(CPF2), .CPF3(CPF3),
    .RATE_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .freq_sel(freq_sel), .test_en(test_en),
    .ch_req(ch_req), .frame_start(frame_start), .frame_done(frame_done),
    .overrun_clr(overrun_clr), .gclk(gclk), .ch_active(ch_active),
    .end_of_one_frame(end_of_one_frame), .frame_overrun(frame_overrun),
    .frame_cycles(frame_cycles), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A frame is described by the edge it started on; everything else is elapsed-edge arithmetic.
  int  edge_n = 0;
  bit  m_active, m_wait, m_over, m_eof, m_ovf;
  int  m_t0, m_budget, m_fc;
  int  last_req [NCH];
  logic [NCH-1:0]   exp_ena;
  logic [CNT_W-1:0] exp_q[$];

  function automatic int cpf_of(input logic [1:0] s);
    case (s)
      2'd0: return CPF0;
      2'd1: return CPF1;
      2'd2: return CPF2;
      default: return CPF3;
    endcase
  endfunction

  function automatic logic [1:0] model_state();
    if (!m_active) return 2'd0;
    if (m_over) return 2'd3;
    if (m_wait) return 2'd2;
    return 2'd1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_wait = 0; m_over = 0; m_eof = 0; m_ovf = 0;
    m_t0 = 0; m_budget = CPF0; m_fc = 0;
    for (int i = 0; i < NCH; i++) last_req[i] = -1000;
  endtask

  // Enable seen by the latch just before the coming edge (edge_n = last edge index).
  function automatic logic [NCH-1:0] model_ena();
    logic [NCH-1:0] e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      bit live;
      bit sup;
      live = ch_req[i] || ((edge_n - last_req[i]) < HOLD);
      sup  = MASK[i] && m_active && m_wait;
      e[i] = test_en || (live && !sup);
    end
    return e;
  endfunction

  task automatic finish_frame();
    m_eof = 1; m_active = 0; m_wait = 0; m_over = 0;
    exp_q.push_back(CNT_W'(m_fc));
  endtask

  task automatic model_step(input int n);
    int k;
    m_eof = 0;
    for (int i = 0; i < NCH; i++) if (ch_req[i]) last_req[i] = n;
    if (overrun_clr) m_ovf = 0;
    if (frame_start) begin
      m_active = 1; m_wait = 0; m_over = 0;
      m_t0 = n; m_budget = cpf_of(freq_sel);
    end else if (m_active) begin
      k = n - m_t0;
      if (m_over) begin
        if (frame_done) begin
          m_fc = (k > SAT) ? SAT : k;
          finish_frame();
        end
      end else if (m_wait) begin
        if (k == m_budget) finish_frame();
      end else if (frame_done) begin
        m_fc = k;
        if (k == m_budget) finish_frame();
        else m_wait = 1;
      end else if (k == m_budget) begin
        m_ovf = 1; m_over = 1;
      end
    end
  endtask

  initial model_reset();

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      exp_ena = '0;
      edge_n++;
    end else begin
      exp_ena = model_ena();
      edge_n++;
      model_step(edge_n);
    end
    #1;
    check("ch_active", ch_active, exp_ena);
    check("gclk_high_phase", gclk, exp_ena);
    check("end_of_one_frame", end_of_one_frame, m_eof);
    check("frame_overrun", frame_overrun, m_ovf);
    check("frame_cycles", frame_cycles, m_fc);
    check("fsm_state", fsm_state, model_state());
    if (end_of_one_frame === 1'b1) begin
      if (exp_q.size() == 0) check("eof_unexpected", end_of_one_frame, 0);
      else check("eof_frame_cycles", frame_cycles, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    #1;
    check("gclk_low_phase", gclk, 0);
  end

  // Gated clocks may only move on a clk edge (times are multiples of 5).
  int glitch_cnt = 0;
  always @(gclk) if (($time % 5) != 0) glitch_cnt++;

  int g3_pulses = 0;
  always @(posedge gclk[3]) g3_pulses++;

  int oth_cnt = 0;
  always @(posedge clk) begin
    #3;
    if ((gclk & 8'hF7) != 0) oth_cnt++;
  end

  int eof_cnt = 0;
  always @(posedge end_of_one_frame) eof_cnt++;

  // ---------------- driver tasks ----------------
  int t_start;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    freq_sel = sel;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    t_start = edge_n;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic pulse_clr();
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
  endtask

  task automatic wait_eof(input int limit, output int offset);
    bit found;
    found = 0;
    offset = -1;
    for (int i = 0; i < limit && !found; i++) begin
      tick(1);
      if (end_of_one_frame === 1'b1) begin
        found = 1;
        offset = edge_n - t_start;
      end
    end
    if (!found) check("eof_timeout", end_of_one_frame, 1);
  endtask

  // ---------------- directed stimulus ----------------
  int off, base;

  initial begin
    reset = 1'b1; test_en = 1'b0; ch_req = '0; freq_sel = 2'd0;
    frame_start = 1'b0; frame_done = 1'b0; overrun_clr = 1'b0;
    tick(2);
    check("rst_ch_active", ch_active, 0);
    check("rst_gclk", gclk, 0);
    check("rst_eof", end_of_one_frame, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_frame_cycles", frame_cycles, 0);
    check("rst_state", fsm_state, 0);
    test_en = 1'b1;
    @(posedge clk); #2;
    check("rst_test_en_gclk", gclk, 0);
    tick(1);
    test_en = 1'b0;
    reset = 1'b0;
    tick(2);

    // one-cycle request on channel 3 gives three full gated pulses
    base = g3_pulses; oth_cnt = 0;
    ch_req = 8'h08; tick(1); ch_req = '0; tick(6);
    check("hold_g3_pulses", g3_pulses - base, 3);
    check("hold_other_channels", oth_cnt, 0);

    // early frame_done: channel 0 gated until the 20-cycle budget ends
    ch_req = 8'h01;
    pulse_start(2'd0);
    tick(7); pulse_done();
    check("early_frame_cycles", frame_cycles, 8);
    tick(2);
    check("early_ch0_suppressed", ch_active[0], 0);
    wait_eof(30, off);
    check("early_eof_offset", off, 20);
    check("early_no_overrun", frame_overrun, 0);
    ch_req = '0;

    // overrun at budget 10, late done at 16, then clear
    pulse_start(2'd1);
    tick(9);
    check("ovr_before_budget", frame_overrun, 0);
    tick(1);
    check("ovr_at_budget", frame_overrun, 1);
    tick(5); pulse_done();
    check("ovr_frame_cycles", frame_cycles, 16);
    check("ovr_eof", end_of_one_frame, 1);
    pulse_clr();
    check("ovr_cleared", frame_overrun, 0);

    // clear coincident with set loses; long overrun saturates the count
    pulse_start(2'd1);
    tick(9); pulse_clr();
    check("ovr_set_beats_clr", frame_overrun, 1);
    tick(29); pulse_done();
    check("sat_frame_cycles", frame_cycles, SAT);
    pulse_clr();

    // freq_sel change mid-frame keeps the latched budget
    pulse_start(2'd0);
    tick(2); freq_sel = 2'd3;
    tick(10);
    check("sel_no_overrun_at_12", frame_overrun, 0);
    tick(8);
    check("sel_overrun_at_20", frame_overrun, 1);
    pulse_clr();
    pulse_start(2'd3);
    tick(4); pulse_done();
    check("sel_frame_cycles", frame_cycles, 5);
    wait_eof(20, off);
    check("sel_eof_offset_cpf3", off, 12);

    // frame_start wins over a simultaneous frame_done
    pulse_start(2'd0);
    tick(4);
    base = eof_cnt;
    frame_done = 1'b1;
    pulse_start(2'd0);
    frame_done = 1'b0;
    check("restart_frame_cycles_kept", frame_cycles, 5);
    check("restart_state_count", fsm_state, 1);
    tick(9);
    check("restart_no_eof", eof_cnt - base, 0);
    tick(2); pulse_done();
    check("restart_frame_cycles", frame_cycles, 12);
    wait_eof(20, off);
    check("restart_eof_offset", off, 20);

    // random request traffic across a budget-15 frame
    base = eof_cnt;
    pulse_start(2'd2);
    for (int i = 0; i < 40; i++) begin
      ch_req = NCH'($urandom_range(0, 255));
      frame_done = (i == 6);
      tick(1);
    end
    ch_req = '0; frame_done = 1'b0;
    check("rand_eof_count", eof_cnt - base, 1);

    // reset during WAIT with test_en high abandons the frame
    pulse_start(2'd0);
    tick(2); pulse_done();
    test_en = 1'b1;
    tick(2);
    check("rst_wait_state", fsm_state, 2);
    base = eof_cnt;
    reset = 1'b1;
    @(posedge clk); #2;
    check("rst_wait_gclk", gclk, 0);
    tick(1);
    check("rst_wait_idle", fsm_state, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("rst_after_idle", fsm_state, 0);
    tick(25);
    check("rst_no_eof", eof_cnt - base, 0);
    test_en = 1'b0;
    tick(3);

    check("eof_queue_drained", exp_q.size(), 0);
    check("no_glitches", glitch_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
